seq_arb_rr_granthold_param: RTL and testbench

//  Parametrised N-input round-robin arbiter with grant hold and bounded hold time.

---
 rtl/seq_arb_rr_granthold_param_if.sv | 32 +++
 rtl/seq_arb_rr_granthold_param.sv | 86 ++++++++
 tb/tb_seq_arb_rr_granthold_param.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_arb_rr_granthold_param_if.sv
// Request/grant bundle for the parametrised round-robin grant-hold arbiter.
// The requester side uses the master modport; the arbiter uses the slave modport.
interface seq_arb_rr_granthold_param_if #(
    parameter int NREQS = 4
);
    localparam int IDX_W = $clog2(NREQS);

    logic [NREQS-1:0] reqs;
    logic [NREQS-1:0] holds;
    logic [NREQS-1:0] grants;
    logic             grant_val;
    logic [IDX_W-1:0] grant_idx;
    logic             hold_expired;

    modport master (
        output reqs,
        output holds,
        input  grants,
        input  grant_val,
        input  grant_idx,
        input  hold_expired
    );

    modport slave (
        input  reqs,
        input  holds,
        output grants,
        output grant_val,
        output grant_idx,
        output hold_expired
    );
endinterface

// File: rtl/seq_arb_rr_granthold_param.sv
// N-input round-robin arbiter with grant hold; MAX_HOLD caps consecutive held
// grants so a holder cannot starve the others (0 = unlimited hold).
module seq_arb_rr_granthold_param #(
    parameter int NREQS    = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    seq_arb_rr_granthold_param_if.slave bus
);
    localparam int IDX_W = $clog2(NREQS);
    localparam int CNT_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD);
    localparam logic [NREQS-1:0] PRIO_INIT  = {{(NREQS-1){1'b0}}, 1'b1};

    // Arbitration state
    logic [NREQS-1:0] prio;
    logic [NREQS-1:0] last_grant;
    logic             hold_pend;
    logic [CNT_W-1:0] hold_cnt;

    // Combinational grant path
    logic               holder_req;
    logic               under_limit;
    logic               held;
    logic [2*NREQS-1:0] req_dbl;
    logic [2*NREQS-1:0] scan_dbl;
    logic [NREQS-1:0]   fresh_grant;
    logic [NREQS-1:0]   grant_int;
    logic [NREQS-1:0]   grants;
    logic [IDX_W-1:0]   idx_int;
    logic               fresh_taken;

    assign holder_req  = hold_pend & (|(last_grant & bus.reqs));
    assign under_limit = (MAX_HOLD == 0) || (hold_cnt < HOLD_LIMIT);
    assign held        = holder_req & under_limit;

    // Subtracting the one-hot prio from the doubled request vector isolates the
    // first request at or above prio; the upper copy handles the wrap to bit 0.
    assign req_dbl     = {bus.reqs, bus.reqs};
    assign scan_dbl    = req_dbl & ~(req_dbl - {{NREQS{1'b0}}, prio});
    assign fresh_grant = scan_dbl[NREQS-1:0] | scan_dbl[2*NREQS-1:NREQS];

    assign grant_int   = held ? last_grant : fresh_grant;
    assign grants      = reset ? grant_int : '0;
    assign fresh_taken = (|grants) & ~held;

    // NOTE: every variable assigned in always_comb gets a default first, otherwise
    // paths that skip an assignment infer a latch.
    always_comb begin
        idx_int = '0;
        for (int i = 0; i < NREQS; i++) begin
            if (grants[i]) begin
                idx_int = idx_int | IDX_W'(i);
            end
        end
    end

    assign bus.grants       = grants;
    assign bus.grant_val    = |grants;
    assign bus.grant_idx    = idx_int;
    assign bus.hold_expired = reset & holder_req & ~held;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            prio       <= PRIO_INIT;
            last_grant <= '0;
            hold_pend  <= 1'b0;
            hold_cnt   <= '0;
        end else begin
            last_grant <= grants;
            hold_pend  <= |(grants & bus.holds);
            // With unlimited hold the count is never consulted, so it stays at 0.
            if (held && (MAX_HOLD != 0)) begin
                hold_cnt <= hold_cnt + 1'b1;
            end else begin
                hold_cnt <= '0;
            end
            if (fresh_taken) begin
                prio <= {grants[NREQS-2:0], grants[NREQS-1]};
            end
        end
    end
endmodule

// File: tb/tb_seq_arb_rr_granthold_param.sv
// Self-checking bench: directed scenarios on NREQS=4/MAX_HOLD=3 and NREQS=8/MAX_HOLD=0,
// then randomized traffic on four configurations against a behavioural model.
module tb_seq_arb_rr_granthold_param;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    seq_arb_rr_granthold_param_if #(.NREQS(2)) bus2 ();
    seq_arb_rr_granthold_param_if #(.NREQS(4)) bus4 ();
    seq_arb_rr_granthold_param_if #(.NREQS(5)) bus5 ();
    seq_arb_rr_granthold_param_if #(.NREQS(8)) bus8 ();

    seq_arb_rr_granthold_param #(.NREQS(2), .MAX_HOLD(3)) u2 (.clk(clk), .reset(reset), .bus(bus2));
    seq_arb_rr_granthold_param #(.NREQS(4), .MAX_HOLD(3)) u4 (.clk(clk), .reset(reset), .bus(bus4));
    seq_arb_rr_granthold_param #(.NREQS(5), .MAX_HOLD(3)) u5 (.clk(clk), .reset(reset), .bus(bus5));
    seq_arb_rr_granthold_param #(.NREQS(8), .MAX_HOLD(0)) u8 (.clk(clk), .reset(reset), .bus(bus8));

    task automatic idle_all();
        bus2.reqs = '0; bus2.holds = '0;
        bus4.reqs = '0; bus4.holds = '0;
        bus5.reqs = '0; bus5.holds = '0;
        bus8.reqs = '0; bus8.holds = '0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        idle_all();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic drive4(input logic [3:0] r, input logic [3:0] h);
        @(negedge clk);
        bus4.reqs  = r;
        bus4.holds = h;
        #1;
    endtask

    task automatic drive8(input logic [7:0] r, input logic [7:0] h);
        @(negedge clk);
        bus8.reqs  = r;
        bus8.holds = h;
        #1;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            reset = 1'b0;
            bus2.reqs = '1; bus4.reqs = '1; bus5.reqs = '1; bus8.reqs = '1;
            bus2.holds = '1; bus4.holds = '1; bus5.holds = '1; bus8.holds = '1;
            #1;
            checks++;
            if ({bus2.grants, bus4.grants, bus5.grants, bus8.grants} !== 19'd0) begin
                errors++;
                $display("FAIL reset_grants cyc=%0d got %b/%b/%b/%b want all zero",
                         c, bus2.grants, bus4.grants, bus5.grants, bus8.grants);
            end
            checks++;
            if ({bus2.grant_val, bus4.grant_val, bus5.grant_val, bus8.grant_val,
                 bus2.hold_expired, bus4.hold_expired, bus5.hold_expired, bus8.hold_expired} !== 8'd0) begin
                errors++;
                $display("FAIL reset_flags cyc=%0d grant_val/hold_expired not all zero", c);
            end
            checks++;
            if (bus4.grant_idx !== 2'd0 || bus8.grant_idx !== 3'd0) begin
                errors++;
                $display("FAIL reset_idx cyc=%0d got %0d/%0d want 0/0", c, bus4.grant_idx, bus8.grant_idx);
            end
        end
        @(negedge clk);
        reset = 1'b1;
        idle_all();
    endtask

    task automatic test_single_sweep();
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            drive4(4'(1 << i), 4'b0000);
            checks++;
            if (bus4.grants !== 4'(1 << i)) begin
                errors++;
                $display("FAIL sweep_grants i=%0d got %b want %b", i, bus4.grants, 4'(1 << i));
            end
            checks++;
            if (bus4.grant_idx !== 2'(i) || bus4.grant_val !== 1'b1) begin
                errors++;
                $display("FAIL sweep_idx i=%0d got idx=%0d val=%b want idx=%0d val=1",
                         i, bus4.grant_idx, bus4.grant_val, i);
            end
            checks++;
            if (bus4.hold_expired !== 1'b0) begin
                errors++;
                $display("FAIL sweep_expired i=%0d got %b want 0", i, bus4.hold_expired);
            end
        end
    endtask

    task automatic test_round_robin();
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            drive4(4'b1111, 4'b0000);
            checks++;
            if (bus4.grants !== 4'(1 << (i % 4))) begin
                errors++;
                $display("FAIL rr_grants cyc=%0d got %b want %b", i, bus4.grants, 4'(1 << (i % 4)));
            end
            checks++;
            if (bus4.grant_idx !== 2'(i % 4)) begin
                errors++;
                $display("FAIL rr_idx cyc=%0d got %0d want %0d", i, bus4.grant_idx, i % 4);
            end
        end
    endtask

    task automatic test_hold_limit();
        logic [3:0] exp_g [6] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0100};
        logic       exp_x [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            drive4(4'b1111, 4'b0001);
            checks++;
            if (bus4.grants !== exp_g[i]) begin
                errors++;
                $display("FAIL hold_grants cyc=%0d got %b want %b", i + 1, bus4.grants, exp_g[i]);
            end
            checks++;
            if (bus4.hold_expired !== exp_x[i]) begin
                errors++;
                $display("FAIL hold_expired cyc=%0d got %b want %b", i + 1, bus4.hold_expired, exp_x[i]);
            end
        end
    endtask

    task automatic test_hold_drop();
        logic [3:0] r_tab [3] = '{4'b1111, 4'b1110, 4'b1111};
        logic [3:0] h_tab [3] = '{4'b0001, 4'b0000, 4'b0000};
        logic [3:0] exp_g [3] = '{4'b0001, 4'b0010, 4'b0100};
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            drive4(r_tab[i], h_tab[i]);
            checks++;
            if (bus4.grants !== exp_g[i] || bus4.hold_expired !== 1'b0) begin
                errors++;
                $display("FAIL drop_grants cyc=%0d got %b exp=%b want %b exp=0",
                         i + 1, bus4.grants, bus4.hold_expired, exp_g[i]);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        apply_reset();
        drive4(4'b1111, 4'b0000);
        drive4(4'b1111, 4'b0000);
        checks++;
        if (bus4.grants !== 4'b0010) begin
            errors++;
            $display("FAIL midrst_pre got %b want 0010", bus4.grants);
        end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            reset = 1'b0;
            #1;
            checks++;
            if (bus4.grants !== 4'b0000 || bus4.grant_val !== 1'b0) begin
                errors++;
                $display("FAIL midrst_during cyc=%0d got %b val=%b want 0000 val=0",
                         c, bus4.grants, bus4.grant_val);
            end
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (bus4.grants !== 4'b0001) begin
            errors++;
            $display("FAIL midrst_release got %b want 0001", bus4.grants);
        end
        drive4(4'b1111, 4'b0000);
        checks++;
        if (bus4.grants !== 4'b0010) begin
            errors++;
            $display("FAIL midrst_next got %b want 0010", bus4.grants);
        end

        // A hold requested just before reset must not survive it.
        apply_reset();
        drive4(4'b1111, 4'b0000);
        drive4(4'b1111, 4'b0010);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        bus4.holds = 4'b0000;
        #1;
        checks++;
        if (bus4.grants !== 4'b0001 || bus4.hold_expired !== 1'b0) begin
            errors++;
            $display("FAIL midrst_hold got %b exp=%b want 0001 exp=0", bus4.grants, bus4.hold_expired);
        end
    endtask

    task automatic test_unlimited_hold();
        apply_reset();
        for (int i = 0; i < 20; i++) begin
            drive8(8'hFF, 8'h01);
            checks++;
            if (bus8.grants !== 8'h01 || bus8.hold_expired !== 1'b0) begin
                errors++;
                $display("FAIL unlim_grants cyc=%0d got %h exp=%b want 01 exp=0",
                         i + 1, bus8.grants, bus8.hold_expired);
            end
        end
        // The hold requested in the last held cycle still applies to the next one.
        drive8(8'hFF, 8'h00);
        checks++;
        if (bus8.grants !== 8'h01) begin
            errors++;
            $display("FAIL unlim_tail got %h want 01", bus8.grants);
        end
        drive8(8'hFF, 8'h00);
        checks++;
        if (bus8.grants !== 8'h02 || bus8.grant_idx !== 3'd1) begin
            errors++;
            $display("FAIL unlim_release got %h idx=%0d want 02 idx=1", bus8.grants, bus8.grant_idx);
        end
    endtask

    task automatic test_random();
        int         n   [4] = '{2, 4, 5, 8};
        int         mh  [4] = '{3, 3, 3, 0};
        int         m_prio [4];
        int         m_last [4];
        int         m_cnt  [4];
        bit         m_pend [4];
        logic [7:0] r  [4];
        logic [7:0] h  [4];
        logic [7:0] og [4];
        logic       ov [4];
        logic       ox [4];
        int         oi [4];
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            m_prio[k] = 0; m_last[k] = -1; m_cnt[k] = 0; m_pend[k] = 1'b0;
        end
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 24) != 0);
            for (int k = 0; k < 4; k++) begin
                logic [7:0] mask;
                mask = 8'((1 << n[k]) - 1);
                r[k] = 8'($urandom) & mask;
                if (m_last[k] >= 0 && $urandom_range(0, 3) != 0) r[k][m_last[k]] = 1'b1;
                h[k] = ($urandom_range(0, 1) == 1) ? mask : (8'($urandom) & mask);
            end
            bus2.reqs = r[0][1:0]; bus2.holds = h[0][1:0];
            bus4.reqs = r[1][3:0]; bus4.holds = h[1][3:0];
            bus5.reqs = r[2][4:0]; bus5.holds = h[2][4:0];
            bus8.reqs = r[3];      bus8.holds = h[3];
            #1;
            og[0] = 8'(bus2.grants); ov[0] = bus2.grant_val; oi[0] = int'(bus2.grant_idx); ox[0] = bus2.hold_expired;
            og[1] = 8'(bus4.grants); ov[1] = bus4.grant_val; oi[1] = int'(bus4.grant_idx); ox[1] = bus4.hold_expired;
            og[2] = 8'(bus5.grants); ov[2] = bus5.grant_val; oi[2] = int'(bus5.grant_idx); ox[2] = bus5.hold_expired;
            og[3] = 8'(bus8.grants); ov[3] = bus8.grant_val; oi[3] = int'(bus8.grant_idx); ox[3] = bus8.hold_expired;
            for (int k = 0; k < 4; k++) begin
                bit         holder, held, e_x;
                int         g, e_i;
                logic [7:0] e_g;
                holder = m_pend[k] && (m_last[k] >= 0) && r[k][m_last[k]];
                held   = holder && (mh[k] == 0 || m_cnt[k] < mh[k]);
                g = -1;
                if (held) begin
                    g = m_last[k];
                end else begin
                    for (int j = 0; j < n[k]; j++) begin
                        int c;
                        c = (m_prio[k] + j) % n[k];
                        if (g < 0 && r[k][c]) g = c;
                    end
                end
                e_g = (reset && g >= 0) ? (8'd1 << g) : 8'd0;
                e_i = (reset && g >= 0) ? g : 0;
                e_x = reset && holder && !held;
                checks++;
                if (og[k] !== e_g || ov[k] !== (e_g != 0) || oi[k] != e_i) begin
                    errors++;
                    $display("FAIL rand_grant n=%0d cyc=%0d reqs=%b got g=%b v=%b i=%0d want g=%b i=%0d",
                             n[k], cyc, r[k], og[k], ov[k], oi[k], e_g, e_i);
                end
                checks++;
                if (ox[k] !== e_x) begin
                    errors++;
                    $display("FAIL rand_expired n=%0d cyc=%0d got %b want %b", n[k], cyc, ox[k], e_x);
                end
                checks++;
                if ((og[k] & (og[k] - 8'd1)) != 8'd0 || (og[k] & ~r[k]) != 8'd0) begin
                    errors++;
                    $display("FAIL rand_onehot n=%0d cyc=%0d got %b reqs=%b want one-hot subset",
                             n[k], cyc, og[k], r[k]);
                end
                if (!reset) begin
                    m_prio[k] = 0; m_last[k] = -1; m_cnt[k] = 0; m_pend[k] = 1'b0;
                end else begin
                    m_pend[k] = (g >= 0) && h[k][g];
                    m_cnt[k]  = held ? m_cnt[k] + 1 : 0;
                    if (g >= 0 && !held) m_prio[k] = (g + 1) % n[k];
                    m_last[k] = g;
                end
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        idle_all();
        test_reset();
        test_single_sweep();
        test_round_robin();
        test_hold_limit();
        test_hold_drop();
        test_reset_mid_run();
        test_unlimited_hold();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
